register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers x0..x31.
//   Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
//   Sits in the decode stage of the RISC-V core.
//   The write port is driven from writeback.
//   x0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  32  register width in bits
//   ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH = 32 registers
// PORTS
//   clock    in   1           system clock; all state updates on the rising edge
//   reset    in   1           synchronous, active-high reset
//   enable   in   1           write enable for the rd port
//   rdAdrs   in   ADDR_WIDTH  write (destination) register address
//   rdData   in   DATA_WIDTH  write data
//   rs1Adrs  in   ADDR_WIDTH  read port 1 address
//   rs2Adrs  in   ADDR_WIDTH  read port 2 address
//   rs1Data  out  DATA_WIDTH  read port 1 data
//   rs2Data  out  DATA_WIDTH  read port 2 data
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset: at a rising edge with reset=1, x1..x31 all become 0.
//     Reset takes priority over a write in the same cycle.
//     During reset, outputs follow the read rules, so they read 0 after that edge.
//   - Write: at a rising edge with reset=0, enable=1 and rdAdrs!=0,
//     regs[rdAdrs] <= rdData.
//     A write to x0 is discarded.
//     enable=0 leaves every register unchanged.
//   - Read: purely combinational, zero-cycle latency.
//     rsNData = (rsNAdrs==0) ? 0 : regs[rsNAdrs].
//     The output follows an address change within the same cycle.
//   - Read/write same address, same cycle: no internal bypass.
//     Before the edge the read shows the old value; after the edge it shows the new one.
//     Forwarding is the pipeline's job.
//   - Both read ports are independent.
//     rs1Adrs==rs2Adrs returns the same value on both.
//   - x0 always reads 0, including before any reset.
//     Other registers are undefined until the first reset or write.
//   - No overflow or wrap concerns: addresses cover exactly 32 entries.
//   - Data is stored and returned unmodified, full width.
// TESTING
//   1. Reset, then read x1..x31 on both ports -> all 0.
//   2. enable=1, rd=1, data=20, one edge; rs1=1 -> rs1Data=20.
//      Then write x2=286 and x4=1024; rs1=2, rs2=4 -> 286 and 1024.
//   3. enable=0, rd=5, data=12, one edge; rs1=rs2=5 -> both 0 (no write).
//      Then enable=1, one edge -> both 12.
//   4. enable=1, rd=0, data=0xDEADBEEF, one edge; rs1=0 -> rs1Data=0.
//   5. Before an edge, present rd=rs1=7 with data=99 -> rs1Data shows old x7.
//      After the edge -> 99.
//   6. Assert reset together with enable=1, rd=3, data=55 -> x3 reads 0 after the edge.
//      Also: reset after loading x1=20 -> x1 reads 0.

Source files
------------

// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit, x0 hardwired to zero; two combinational reads, one write.
// Reads are combinational (0 cycles), writes land on the rising edge; no backpressure, no internal bypass.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] rdAdrs,
  input  logic [DATA_WIDTH-1:0] rdData,
  input  logic [ADDR_WIDTH-1:0] rs1Adrs,
  input  logic [ADDR_WIDTH-1:0] rs2Adrs,
  output logic [DATA_WIDTH-1:0] rs1Data,
  output logic [DATA_WIDTH-1:0] rs2Data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is never written; reads of x0 are forced to zero below.
  logic [DATA_WIDTH-1:0] regs [0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (enable && (rdAdrs != '0)) begin
      regs[rdAdrs] <= rdData;
    end
  end

  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (rs1Adrs != '0) rs1Data = regs[rs1Adrs];
    if (rs2Adrs != '0) rs2Data = regs[rs2Adrs];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read values, a negedge monitor pops and compares.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  rdAdrs;
  logic [31:0] rdData;
  logic [4:0]  rs1Adrs;
  logic [4:0]  rs2Adrs;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  register_file dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .rdAdrs  (rdAdrs),
    .rdData  (rdData),
    .rs1Adrs (rs1Adrs),
    .rs2Adrs (rs2Adrs),
    .rs1Data (rs1Data),
    .rs2Data (rs2Data)
  );

  always #5 clock = ~clock;

  // Monitor: reads are sampled mid-cycle, away from the write edge.
  always @(negedge clock) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        mismatched++;
        compared++;
        $display("FAIL scoreboard_underflow: sample strobe with empty expectation queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        compared++;
        if (rs1Data !== e.e1) begin
          mismatched++;
          $display("FAIL %s rs1Data: got %h want %h", e.name, rs1Data, e.e1);
        end
        compared++;
        if (rs2Data !== e.e2) begin
          mismatched++;
          $display("FAIL %s rs2Data: got %h want %h", e.name, rs2Data, e.e2);
        end
      end
    end
  end

  task automatic check(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] x1, input logic [31:0] x2, input string nm);
    exp_t e;
    rs1Adrs = a1;
    rs2Adrs = a2;
    e.e1 = x1;
    e.e2 = x2;
    e.name = nm;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clock);
    #1 chk_vld = 1'b0;
  endtask

  task automatic write(input logic en, input logic [4:0] adr, input logic [31:0] dat);
    enable = en;
    rdAdrs = adr;
    rdData = dat;
    @(posedge clock);
    #1 enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    rdAdrs = '0;
    rdData = '0;
    rs1Adrs = '0;
    rs2Adrs = '0;
    @(posedge clock);
    #1;
    check(5'd0, 5'd0, 32'd0, 32'd0, "x0_before_reset");

    // 1. reset, every register reads zero on both ports
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      check(i[4:0], 5'(32 - i), 32'd0, 32'd0, "reset_all_zero");
    end

    // 2. basic writes, independent ports
    write(1'b1, 5'd1, 32'd20);
    check(5'd1, 5'd0, 32'd20, 32'd0, "write_x1");
    write(1'b1, 5'd2, 32'd286);
    write(1'b1, 5'd4, 32'd1024);
    check(5'd2, 5'd4, 32'd286, 32'd1024, "read_x2_x4");
    check(5'd4, 5'd2, 32'd1024, 32'd286, "addr_swap");

    // 3. enable gating, then same address on both ports
    write(1'b0, 5'd5, 32'd12);
    check(5'd5, 5'd5, 32'd0, 32'd0, "enable_low_no_write");
    write(1'b1, 5'd5, 32'd12);
    check(5'd5, 5'd5, 32'd12, 32'd12, "enable_high_write");

    // 4. writes to x0 are discarded
    write(1'b1, 5'd0, 32'hDEADBEEF);
    check(5'd0, 5'd1, 32'd0, 32'd20, "x0_write_discarded");

    // 5. no bypass: old value before the edge, new value after
    write(1'b1, 5'd7, 32'h0000_1234);
    enable = 1'b1;
    rdAdrs = 5'd7;
    rdData = 32'd99;
    check(5'd7, 5'd7, 32'h0000_1234, 32'h0000_1234, "no_bypass_before_edge");
    @(posedge clock);
    #1 enable = 1'b0;
    check(5'd7, 5'd31, 32'd99, 32'd0, "after_edge_new_value");

    // 6. reset wins over a simultaneous write
    write(1'b1, 5'd3, 32'd77);
    check(5'd3, 5'd1, 32'd77, 32'd20, "x3_loaded");
    reset = 1'b1;
    enable = 1'b1;
    rdAdrs = 5'd3;
    rdData = 32'd55;
    @(posedge clock);
    #1 reset = 1'b0;
    enable = 1'b0;
    check(5'd3, 5'd1, 32'd0, 32'd0, "reset_priority_x3_x1");
    check(5'd2, 5'd7, 32'd0, 32'd0, "reset_clears_x2_x7");
    write(1'b1, 5'd31, 32'hFFFF_FFFF);
    check(5'd31, 5'd30, 32'hFFFF_FFFF, 32'd0, "full_width_x31");

    repeat (2) @(posedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
